// File: rtl/psubsb_seq.sv
// Sequential lane-wise saturating signed subtract (PSUBSB), one lane per clock behind valid/ready.
// Optional per-lane saturation flags port enabled by defining PSUBSB_SAT_FLAGS_EN.
module psubsb_seq #(
   parameter int LANE_W = 4,
   parameter int LANES  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANE_W*LANES-1:0]   A,
   input  logic [LANE_W*LANES-1:0]   B,
   output logic                      out_valid,
   input  logic                      out_ready,
`ifdef PSUBSB_SAT_FLAGS_EN
   output logic [LANES-1:0]          sat_flags,
`endif
   output logic [LANE_W*LANES-1:0]   Diff
);

   localparam int DW = LANE_W * LANES;
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   diff_q, diff_d;
   logic            out_valid_q, out_valid_d;
   logic [LANE_W:0] lane_res_s;
`ifdef PSUBSB_SAT_FLAGS_EN
   logic [LANES-1:0] flags_q, flags_d;
`endif

   // Returns {overflow, saturated lane difference}; overflow only possible when signs differ.
   function automatic logic [LANE_W:0] sat_sub(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
      logic [LANE_W-1:0] d;
      logic [LANE_W-1:0] res;
      logic              ovf;
      d   = a - b;
      ovf = (a[LANE_W-1] != b[LANE_W-1]) && (d[LANE_W-1] != a[LANE_W-1]);
      if (ovf) begin
         if (a[LANE_W-1]) begin
            res = {1'b1, {(LANE_W-1){1'b0}}};
         end else begin
            res = {1'b0, {(LANE_W-1){1'b1}}};
         end
      end else begin
         res = d;
      end
      return {ovf, res};
   endfunction

   assign lane_res_s = sat_sub(a_q[int'(cnt_q)*LANE_W +: LANE_W],
                               b_q[int'(cnt_q)*LANE_W +: LANE_W]);

   // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      out_valid_d = out_valid_q;
`ifdef PSUBSB_SAT_FLAGS_EN
      flags_d     = flags_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d         = A;
               b_d         = B;
               diff_d      = '0;
               cnt_d       = '0;
               out_valid_d = 1'b0;
`ifdef PSUBSB_SAT_FLAGS_EN
               flags_d     = '0;
`endif
               state_d     = CALC;
            end else begin
               state_d     = IDLE;
            end
         end
         CALC: begin
            diff_d[int'(cnt_q)*LANE_W +: LANE_W] = lane_res_s[LANE_W-1:0];
`ifdef PSUBSB_SAT_FLAGS_EN
            flags_d[cnt_q] = lane_res_s[LANE_W];
`endif
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_LANE) begin
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               state_d     = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d     = DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         out_valid_q <= 1'b0;
`ifdef PSUBSB_SAT_FLAGS_EN
         flags_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         out_valid_q <= out_valid_d;
`ifdef PSUBSB_SAT_FLAGS_EN
         flags_q     <= flags_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign Diff      = diff_q;
`ifdef PSUBSB_SAT_FLAGS_EN
   assign sat_flags = flags_q;
`endif

endmodule

// File: tb/tb_psubsb_seq.sv
// Directed self-checking bench for psubsb_seq: lane results, latency, backpressure, mid-op reset.
// Saturation flag checks are compiled in only when PSUBSB_SAT_FLAGS_EN is defined.
module tb_psubsb_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Diff;
`ifdef PSUBSB_SAT_FLAGS_EN
   logic [3:0]  sat_flags;
`endif

   int checks = 0;
   int errors = 0;

   psubsb_seq #(.LANE_W(4), .LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef PSUBSB_SAT_FLAGS_EN
      .sat_flags (sat_flags),
`endif
      .Diff      (Diff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input logic [3:0] exp, input string tag);
`ifdef PSUBSB_SAT_FLAGS_EN
      check({28'd0, sat_flags}, {28'd0, exp}, tag);
`else
      if (exp === 4'hx) $display("unreachable %s", tag);
`endif
   endtask

   // Issue one operation and follow it lane by lane until out_valid; leaves it in DONE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic [3:0] exp_f);
      logic [15:0] mask;
      @(negedge clk);
      A        = a;
      B        = b;
      in_valid = 1'b1;
      check({31'd0, in_ready}, 32'd1, "ready_before_accept");
      @(negedge clk);
      in_valid = 1'b0;
      A        = ~a;
      B        = ~b;
      check({31'd0, in_ready}, 32'd0, "ready_in_calc");
      check({16'd0, Diff}, 32'd0, "diff_cleared_on_accept");
      mask = 16'h000F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({31'd0, out_valid}, 32'd0, "valid_low_in_calc");
         check({16'd0, Diff}, {16'd0, exp_d & mask}, "partial_diff");
         mask = {mask[11:0], 4'hF};
      end
      @(negedge clk);
      check({31'd0, out_valid}, 32'd1, "valid_after_4");
      check({16'd0, Diff}, {16'd0, exp_d}, "diff_result");
      check({31'd0, in_ready}, 32'd0, "ready_in_done");
      check_flags(exp_f, "sat_flags");
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({31'd0, out_valid}, 32'd0, "valid_drop");
      check({31'd0, in_ready}, 32'd1, "ready_back");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 16'h0000;
      B         = 16'h0000;
      repeat (2) @(negedge clk);
      check({31'd0, out_valid}, 32'd0, "rst_valid");
      check({16'd0, Diff}, 32'd0, "rst_diff");
      check_flags(4'h0, "rst_flags");
      rst_n = 1'b1;
      #1;
      check({31'd0, in_ready}, 32'd1, "rst_ready");

      run_op(16'h1234, 16'h1111, 16'h0123, 4'h0);
      release_result();
      run_op(16'h7777, 16'hFFFF, 16'h7777, 4'hF);
      release_result();
      run_op(16'h8888, 16'h1111, 16'h8888, 4'hF);
      release_result();
      run_op(16'h7830, 16'hF158, 16'h78E7, 4'hD);
      release_result();
      run_op(16'h0878, 16'h81F8, 16'h7870, 4'hE);
      release_result();
      run_op(16'h8888, 16'h8888, 16'h0000, 4'h0);
      release_result();

      // Backpressure: result held for 10 cycles while new operands are offered.
      run_op(16'h1234, 16'h1111, 16'h0123, 4'h0);
      for (int i = 0; i < 10; i++) begin
         A        = 16'h5555;
         B        = 16'h2222;
         in_valid = 1'b1;
         @(negedge clk);
         check({31'd0, out_valid}, 32'd1, "hold_valid");
         check({16'd0, Diff}, 32'h0123, "hold_diff");
         check({31'd0, in_ready}, 32'd0, "hold_ready");
      end
      in_valid = 1'b0;
      release_result();

      // Reset during the second CALC cycle.
      @(negedge clk);
      A        = 16'h7777;
      B        = 16'hFFFF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check({31'd0, out_valid}, 32'd0, "midrst_valid");
      check({16'd0, Diff}, 32'd0, "midrst_diff");
      check({31'd0, in_ready}, 32'd1, "midrst_ready");
      check_flags(4'h0, "midrst_flags");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check({31'd0, in_ready}, 32'd1, "postrst_ready");
      run_op(16'h8000, 16'h8000, 16'h0000, 4'h0);
      release_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
